// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with valid/ready load side.
// Words leave LSB first, one bit per CE-qualified clock, LAST on the final bit.
module piso_shift_reg #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = WIDTH'(8'hDE)
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    input  logic             VALID,
    output logic             READY,
    input  logic             CE,
    output logic             O,
    output logic             O_VALID,
    output logic             LAST
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic busy;
    logic at_last;

    assign busy    = (state == SHIFT);
    assign at_last = (cnt == LAST_CNT);

    // Outputs decode straight from state so reset clears them without a clock.
    assign READY   = !busy && !ASYNCRESET;
    assign O_VALID = busy;
    assign O       = busy && sreg[0];
    assign LAST    = busy && at_last;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= IDLE;
            sreg  <= INIT;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (VALID) begin
                        state <= SHIFT;
                        sreg  <= I;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (CE) begin
                        if (at_last) begin
                            state <= IDLE;
                            sreg  <= INIT;
                            cnt   <= '0;
                        end else begin
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                            cnt  <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sreg  <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Scoreboard bench for piso_shift_reg: accepted words become queued bits,
// a negedge monitor pops and compares the serial stream.
module tb_piso_shift_reg;

    localparam int W = 8;
    localparam logic [W-1:0] INIT = 8'hDE;

    logic         CLK = 1'b0;
    logic         ASYNCRESET;
    logic [W-1:0] I;
    logic         VALID;
    logic         READY;
    logic         CE;
    logic         O;
    logic         O_VALID;
    logic         LAST;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q[$];
    int remaining = 0;
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    piso_shift_reg #(.WIDTH(W), .INIT(INIT)) dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .I(I),
        .VALID(VALID),
        .READY(READY),
        .CE(CE),
        .O(O),
        .O_VALID(O_VALID),
        .LAST(LAST)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: a word is accepted whenever nothing is outstanding; each
    // CE edge consumes one of its bits, and the block is free again only
    // after all WIDTH bits have gone.
    always @(posedge CLK) begin
        if (!ASYNCRESET) begin
            if (remaining == 0) begin
                if (VALID) begin
                    for (int k = 0; k < W; k++)
                        q.push_back('{b: I[k], last: (k == W - 1)});
                    remaining = W;
                end
            end else if (CE) begin
                remaining--;
            end
        end
    end

    always @(posedge ASYNCRESET) begin
        remaining = 0;
        q.delete();
    end

    always @(negedge CLK) begin
        if (!ASYNCRESET) begin
            check("ready", READY, remaining == 0);
            check("o_valid", O_VALID, remaining > 0);
            if (O_VALID) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream: bit emitted with empty queue at %0t",
                             $time);
                end else begin
                    check("o", O, q[0].b);
                    check("last", LAST, q[0].last);
                    if (CE) void'(q.pop_front());
                end
            end else begin
                check("o_idle", O, 0);
                check("last_idle", LAST, 0);
            end
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic ce);
        @(posedge CLK);
        #1;
        VALID = v;
        I = d;
        CE = ce;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        VALID = 1'b0;
        CE = 1'b0;
        I = '0;
        #12;
        check("rst_ready", READY, 0);
        check("rst_ovalid", O_VALID, 0);
        check("rst_o", O, 0);
        check("rst_last", LAST, 0);
        #10 ASYNCRESET = 1'b0;
        #1;
        check("rel_ready", READY, 1);
        check("rel_sreg", dut.sreg, INIT);

        // basic word
        step(1, 8'hDE, 1);
        for (int n = 0; n < W + 2; n++) step(0, 8'h00, 1);

        // CE stall after bit 2
        step(1, 8'hA5, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        for (int n = 0; n < 3; n++) step(0, 8'h00, 0);
        for (int n = 0; n < W; n++) step(0, 8'h00, 1);

        // VALID during busy is ignored
        step(1, 8'h0F, 1);
        for (int n = 0; n < W + 1; n++) step(1, 8'hFF, 1);
        for (int n = 0; n < W + 2; n++) step(0, 8'h00, 1);

        // back-to-back words with one idle gap
        step(1, 8'h01, 1);
        for (int n = 0; n < W + 1; n++) step(1, 8'h80, 1);
        for (int n = 0; n < W + 2; n++) step(0, 8'h00, 1);

        // reset mid-word
        step(1, 8'h3C, 1);
        for (int n = 0; n < 4; n++) step(0, 8'h00, 1);
        @(negedge CLK);
        #2 ASYNCRESET = 1'b1;
        #1;
        check("mid_rst_ovalid", O_VALID, 0);
        check("mid_rst_ready", READY, 0);
        check("mid_rst_o", O, 0);
        check("mid_rst_last", LAST, 0);
        #1 ASYNCRESET = 1'b0;
        #0.5;
        check("mid_rel_ready", READY, 1);
        check("mid_rel_sreg", dut.sreg, INIT);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);

        // random traffic
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), W'($urandom),
                 $urandom_range(0, 3) != 0);

        for (int n = 0; n < W + 3; n++) step(0, 8'h00, 1);
        @(negedge CLK);
        #1;
        check("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
